// File: rtl/count_capture_fifo.sv
// Captures match/wrap events from an 8-bit counter into a first-word-fall-through FIFO.
// Detection is gated by a two-state arm/disarm FSM; lost events latch a sticky overflow flag.
module count_capture_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 count,
    input  logic [7:0]                 cmp_value,
    input  logic                       arm,
    input  logic                       disarm,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [7:0]                 evt_data,
    output logic [1:0]                 evt_kind,
    output logic                       armed,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    typedef enum logic {IDLE, ARMED} state_t;

    state_t        state_q, state_d;
    logic [7:0]    prev_count;
    logic          prev_valid;
    logic          match_p0, wrap_p0, push_p0;
    logic [9:0]    entry_p0;
    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [9:0]    head;
    logic          full, pop, push_ok;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arm && !disarm) state_d = ARMED;
            ARMED:   if (disarm)         state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            prev_count <= 8'h00;
            prev_valid <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_count <= count;
            prev_valid <= 1'b1;
        end
    end

    // Stage p0: edge-qualified event detection against the previous sample
    always_comb begin
        match_p0 = (count == cmp_value) && ((prev_count != cmp_value) || !prev_valid);
        wrap_p0  = prev_valid && (prev_count == 8'hFF) && (count == 8'h00);
        push_p0  = (state_q == ARMED) && (match_p0 || wrap_p0);
        entry_p0 = {wrap_p0, match_p0, count};
    end

    assign full    = (fifo_level == LW'(DEPTH));
    assign pop     = evt_valid && evt_ready;
    assign push_ok = push_p0 && (!full || pop);

    // FIFO storage holds data only; validity comes from fifo_level
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= entry_p0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
            if (state_q == IDLE && state_d == ARMED) overflow <= 1'b0;
            else if (push_p0 && full && !pop)        overflow <= 1'b1;
        end
    end

    assign head      = mem[rd_ptr];
    assign evt_valid = (fifo_level != '0);
    assign evt_data  = evt_valid ? head[7:0] : 8'h00;
    assign evt_kind  = evt_valid ? head[9:8] : 2'b00;
    assign armed     = (state_q == ARMED);

endmodule

// File: tb/tb_count_capture_fifo.sv
// Directed bench for count_capture_fifo (DEPTH = 4): detection, merge, overflow, FIFO order, reset.
module tb_count_capture_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] count;
    logic [7:0] cmp_value;
    logic       arm;
    logic       disarm;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_data;
    logic [1:0] evt_kind;
    logic       armed;
    logic       overflow;
    logic [2:0] fifo_level;

    int n_chk  = 0;
    int n_fail = 0;

    count_capture_fifo #(.DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .count      (count),
        .cmp_value  (cmp_value),
        .arm        (arm),
        .disarm     (disarm),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_data   (evt_data),
        .evt_kind   (evt_kind),
        .armed      (armed),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    int       seen;
    logic [7:0] seen_data;
    logic [1:0] seen_kind;

    initial begin
        reset = 1'b0; count = 8'h00; cmp_value = 8'h05;
        arm = 1'b0; disarm = 1'b0; evt_ready = 1'b0;
        tick(); tick();
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_data",  32'(evt_data),  32'd0);
        chk("rst_kind",  32'(evt_kind),  32'd0);
        chk("rst_armed", 32'(armed),     32'd0);
        chk("rst_ovf",   32'(overflow),  32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        reset = 1'b1;
        tick();

        // basic match over a ramp, consumer always ready
        arm = 1'b1; tick(); arm = 1'b0;
        chk("arm_armed", 32'(armed), 32'd1);
        evt_ready = 1'b1;
        seen = 0; seen_data = 8'h00; seen_kind = 2'b00;
        for (int c = 0; c <= 10; c++) begin
            count = 8'(c);
            tick();
            if (evt_valid) begin
                seen++;
                seen_data = evt_data;
                seen_kind = evt_kind;
            end
        end
        chk("ramp_entries", 32'(seen), 32'd1);
        chk("ramp_data",    32'(seen_data), 32'h05);
        chk("ramp_kind",    32'(seen_kind), 32'd1);
        chk("ramp_armed",   32'(armed), 32'd1);
        chk("ramp_level",   32'(fifo_level), 32'd0);

        // held count produces a single entry
        evt_ready = 1'b0;
        count = 8'h05;
        for (int i = 0; i < 5; i++) tick();
        chk("held_level", 32'(fifo_level), 32'd1);
        chk("held_data",  32'(evt_data), 32'h05);
        chk("held_kind",  32'(evt_kind), 32'd1);
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        chk("held_pop_valid", 32'(evt_valid), 32'd0);

        // wrap coinciding with a match merges to kind 11
        cmp_value = 8'h00;
        count = 8'hFE; tick();
        count = 8'hFF; tick();
        count = 8'h00; tick();
        chk("merge_level", 32'(fifo_level), 32'd1);
        chk("merge_data",  32'(evt_data), 32'h00);
        chk("merge_kind",  32'(evt_kind), 32'd3);
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;

        // pure wrap
        cmp_value = 8'h33;
        count = 8'hFF; tick();
        count = 8'h00; tick();
        chk("wrap_level", 32'(fifo_level), 32'd1);
        chk("wrap_data",  32'(evt_data), 32'h00);
        chk("wrap_kind",  32'(evt_kind), 32'd2);
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        chk("wrap_empty", 32'(fifo_level), 32'd0);

        // five events into a four-deep FIFO
        for (int v = 1; v <= 5; v++) begin
            cmp_value = 8'(v); count = 8'(v); tick();
        end
        chk("ovf_level", 32'(fifo_level), 32'd4);
        chk("ovf_flag",  32'(overflow), 32'd1);
        tick();
        chk("ovf_hold_data", 32'(evt_data), 32'h01);
        evt_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("ovf_order", 32'(evt_data), 32'(i));
            tick();
        end
        evt_ready = 1'b0;
        chk("ovf_drained_valid", 32'(evt_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        disarm = 1'b1; tick(); disarm = 1'b0;
        chk("disarm_armed", 32'(armed), 32'd0);
        chk("disarm_ovf",   32'(overflow), 32'd1);
        arm = 1'b1; tick(); arm = 1'b0;
        chk("rearm_armed", 32'(armed), 32'd1);
        chk("rearm_ovf",   32'(overflow), 32'd0);

        // full FIFO accepts a push when popped in the same cycle
        for (int v = 8'h11; v <= 8'h14; v++) begin
            cmp_value = 8'(v); count = 8'(v); tick();
        end
        chk("full_level", 32'(fifo_level), 32'd4);
        cmp_value = 8'h15; count = 8'h15; evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        chk("pp_level", 32'(fifo_level), 32'd4);
        chk("pp_ovf",   32'(overflow), 32'd0);
        evt_ready = 1'b1;
        for (int v = 8'h12; v <= 8'h15; v++) begin
            chk("pp_order", 32'(evt_data), 32'(v));
            tick();
        end
        evt_ready = 1'b0;
        chk("pp_empty", 32'(fifo_level), 32'd0);

        // disarm keeps stored entries; arm+disarm in IDLE stays IDLE
        for (int v = 8'h21; v <= 8'h23; v++) begin
            cmp_value = 8'(v); count = 8'(v); tick();
        end
        disarm = 1'b1; tick(); disarm = 1'b0;
        chk("noflush_level", 32'(fifo_level), 32'd3);
        chk("noflush_head",  32'(evt_data), 32'h21);
        chk("noflush_armed", 32'(armed), 32'd0);
        arm = 1'b1; disarm = 1'b1; tick(); arm = 1'b0; disarm = 1'b0;
        chk("conflict_armed", 32'(armed), 32'd0);

        // reset with three entries stored
        reset = 1'b0; tick(); reset = 1'b1;
        chk("mrst_level", 32'(fifo_level), 32'd0);
        chk("mrst_valid", 32'(evt_valid), 32'd0);
        chk("mrst_armed", 32'(armed), 32'd0);
        chk("mrst_data",  32'(evt_data), 32'd0);

        // no detection while idle nor in the cycle arm is sampled
        cmp_value = 8'h40;
        count = 8'h40; tick();
        chk("idle_nodet", 32'(fifo_level), 32'd0);
        count = 8'h41; tick();
        count = 8'h40; arm = 1'b1; tick(); arm = 1'b0;
        chk("armcyc_armed", 32'(armed), 32'd1);
        chk("armcyc_nodet", 32'(fifo_level), 32'd0);
        tick();
        chk("armcyc_held", 32'(fifo_level), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/count_capture_fifo.md
COUNT_CAPTURE_FIFO -- requirements
Module: count_capture_fifo

Interface
REQ-001 SHALL have parameter: DEPTH, 4, FIFO entries; power of two, 2..16.
REQ-002 SHALL have ports as follows:
- clk  input  1  rising-edge clock, sole clock domain.
- reset  input  1  synchronous, active-low reset; sampled on clk rising edge.
- count  input  8  live count value from the upstream 8-bit counter.
- cmp_value  input  8  match compare value.
- arm  input  1  level; enables event detection.
- disarm  input  1  level; disables event detection.
- evt_valid  output  1  FIFO head entry available.
- evt_ready  input  1  consumer accepts head entry.
- evt_data  output  8  captured count of head entry.
- evt_kind  output  2  head entry kind: bit0 = match, bit1 = wrap.
- armed  output  1  high in ARMED state.
- overflow  output  1  sticky; event lost because the FIFO was full.
- fifo_level  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.

Function
REQ-003 SHALL register count into prev_count every cycle and set prev_valid high on the first cycle after reset deasserts.
REQ-004 SHALL implement a two-state FSM: IDLE -> ARMED when arm=1 and disarm=0; ARMED -> IDLE when disarm=1; disarm SHALL win when both are high; arm SHALL be ignored in ARMED.
REQ-005 SHALL perform event detection only while the registered state is ARMED; no event SHALL be detected in the cycle in which arm is sampled.
REQ-006 SHALL detect a match event when count == cmp_value and (prev_count != cmp_value or prev_valid = 0), giving one event per arrival, not one per held cycle.
REQ-007 SHALL detect a wrap event when prev_valid = 1, prev_count = 8'hFF and count = 8'h00.
REQ-008 SHALL merge a match and a wrap detected in the same cycle into one entry with evt_kind = 2'b11.
REQ-009 SHALL push one entry, {kind, count}, per detecting cycle.
- Latency: event at cycle N appears at the head no earlier than cycle N+1.
REQ-010 SHALL present the head entry first-word-fall-through: evt_valid = (fifo_level != 0).
REQ-011 SHALL pop on a cycle with evt_valid = 1 and evt_ready = 1; evt_ready while empty SHALL have no effect.
REQ-012 SHALL hold evt_data and evt_kind stable while evt_valid = 1 and evt_ready = 0.
REQ-013 SHALL accept a push when full if a pop occurs in the same cycle; fifo_level is then unchanged.
REQ-014 SHALL, on a simultaneous push and pop when not empty, keep fifo_level unchanged and preserve order.
REQ-015 SHALL drop a push that arrives when full without a pop, leave stored entries unchanged, and set overflow = 1.
REQ-016 SHALL clear overflow only on reset or on an IDLE -> ARMED transition.
REQ-017 SHALL use wrap-around read and write pointers modulo DEPTH, with fifo_level tracking full versus empty.
REQ-018 SHALL NOT flush the FIFO on disarm; stored entries remain poppable in IDLE.

Reset
REQ-019 SHALL, with reset = 0 at a clk edge, apply all of the following:
- Set state to IDLE, clear prev_valid and set prev_count = 0.
- Empty the FIFO and set both pointers = 0.
- Drive outputs to: evt_valid = 0, evt_data = 0, evt_kind = 0, armed = 0, overflow = 0, fifo_level = 0.
REQ-020 SHALL, when reset is asserted mid-operation, discard the FIFO contents and any event detected in that cycle.
- First detection is possible only after a new arm.

Verification
REQ-021 Basic match:
- Stimulus: cmp_value = 8'h05, arm for 1 cycle, count ramps 0..10 with evt_ready = 1.
- Response: exactly one entry, evt_data = 8'h05, evt_kind = 2'b01, armed = 1.
REQ-022 Held count:
- Stimulus: count held at 8'h05 for 5 cycles with cmp_value = 8'h05.
- Response: one entry only.
REQ-023 Wrap with merge:
- Stimulus: cmp_value = 8'h00, count 8'hFE, 8'hFF, 8'h00.
- Response: one entry, evt_data = 8'h00, evt_kind = 2'b11.
REQ-024 Overflow:
- Stimulus: evt_ready = 0, DEPTH = 4, 5 match events.
- Response: fifo_level = 4 and overflow = 1.
- Then evt_ready = 1: the first 4 events pop in order, then evt_valid = 0.
- overflow remains 1 until re-arm.
REQ-025 Full with simultaneous push and pop:
- Stimulus: FIFO full, event coincides with evt_ready = 1.
- Response: fifo_level stays 4, overflow stays 0, new entry appears last.
REQ-026 Arm/disarm conflict and reset:
- Stimulus: arm = disarm = 1 in IDLE.
- Response: stays IDLE, armed = 0.
- Stimulus: reset = 0 with 3 entries stored.
- Response: next cycle fifo_level = 0, evt_valid = 0, armed = 0.
